lfsr_rng: RTL and testbench

Parametrised pseudo-random source. A Galois LFSR of configurable width and tap mask feeds a one-entry registered output buffer with a valid/ready handshake. Each accepted sample carries the raw state and a ranged value `1 + (state % RANGE)`. It sits between game/control logic and any consumer that needs dice-style draws, and replaces the fixed 5-bit generator with a runtime-seedable, back-pressure-aware block.

---
 rtl/lfsr_rng.sv | 90 +++++++++
 tb/tb_lfsr_rng.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng.sv
// Galois LFSR random source with a one-entry valid/ready output buffer and ranged draw.
// Define LFSR_LOCKUP_GUARD_EN to replace a zero seed load with SEED.
module lfsr_rng #(
    parameter int unsigned WIDTH = 32,
    parameter logic [31:0] TAPS  = 32'h8020_0003,
    parameter logic [31:0] SEED  = 32'h0000_001F,
    parameter int unsigned RANGE = 4,
    parameter int unsigned OUT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data,
    output logic [OUT_W-1:0] small_data,
    output logic [15:0]      draw_count
);

    localparam logic [WIDTH-1:0] TAPS_W  = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W  = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RANGE_W = WIDTH'(RANGE);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [OUT_W-1:0] small_q, small_d;
    logic             valid_q, valid_d;
    logic [15:0]      count_q, count_d;

    logic             xfer;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] load_val;
    logic [OUT_W-1:0] ranged;

    assign xfer   = valid_q & out_ready;
    assign step   = (state_q >> 1) ^ (state_q[0] ? TAPS_W : '0);
    // Remainder is below RANGE, so truncating to OUT_W bits before the +1 is lossless.
    assign ranged = OUT_W'(state_q % RANGE_W) + OUT_W'(1);

`ifdef LFSR_LOCKUP_GUARD_EN
    assign load_val = (seed_in == '0) ? SEED_W : seed_in;
`else
    assign load_val = seed_in;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        small_d = small_q;
        valid_d = valid_q;
        count_d = count_q + (xfer ? 16'd1 : 16'd0);
        if (seed_load) begin
            state_d = load_val;
            valid_d = 1'b0;
        end else if (enable) begin
            state_d = step;
            if (!valid_q || xfer) begin
                data_d  = state_q;
                small_d = ranged;
                valid_d = 1'b1;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= SEED_W;
            data_q  <= '0;
            small_q <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            small_q <= small_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign out_valid  = valid_q;
    assign data       = data_q;
    assign small_data = small_q;
    assign draw_count = count_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed bench for lfsr_rng in the 8-bit, taps B8, seed 01, range 4 configuration.
module tb_lfsr_rng;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       seed_load = 1'b0;
    logic [7:0] seed_in = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] data;
    logic [2:0] small_data;
    logic [15:0] draw_count;

    int unsigned compared = 0;
    int unsigned mismatched = 0;

    lfsr_rng #(
        .WIDTH(8),
        .TAPS (32'h0000_00B8),
        .SEED (32'h0000_0001),
        .RANGE(4),
        .OUT_W(3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data      (data),
        .small_data(small_data),
        .draw_count(draw_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] step8(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    logic [7:0] exp_data [6] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    logic [2:0] exp_small [6] = '{3'd2, 3'd1, 3'd1, 3'd3, 3'd4, 3'd4};

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] s;
        bit seen [256];

        #2 reset = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(data), 32'h00);
        check("rst_small", 32'(small_data), 32'd0);
        check("rst_count", 32'(draw_count), 32'd0);

        enable = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #2 reset = 1'b1;

        s = 8'h01;
        foreach (seen[i]) seen[i] = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            tick();
            if (k <= 6) begin
                check("seq_data", 32'(data), 32'(exp_data[k-1]));
                check("seq_small", 32'(small_data), 32'(exp_small[k-1]));
                check("seq_valid", 32'(out_valid), 32'd1);
            end else if (k <= 255) begin
                check("period_data", 32'(data), 32'(s));
            end
            if (k <= 255) begin
                check("no_repeat", 32'(seen[data]), 32'd0);
                seen[data] = 1'b1;
                check("period_count", 32'(draw_count), 32'(k - 1));
            end
            s = step8(s);
        end
        check("wrap_data", 32'(data), 32'h01);
        check("wrap_count", 32'(draw_count), 32'd255);

        // Asynchronous reset pulse entirely between two edges.
        #3 reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(data), 32'h00);
        check("mid_rst_small", 32'(small_data), 32'd0);
        check("mid_rst_count", 32'(draw_count), 32'd0);
        out_ready = 1'b0;
        #2 reset = 1'b1;

        tick();
        check("first_data", 32'(data), 32'h01);
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_count", 32'(draw_count), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_data", 32'(data), 32'h01);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_count", 32'(draw_count), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("release_data", 32'(data), 32'hE1);
        check("release_small", 32'(small_data), 32'd2);
        check("release_count", 32'(draw_count), 32'd1);

        out_ready = 1'b0;
        seed_load = 1'b1;
        seed_in = 8'h5A;
        tick();
        check("load_valid", 32'(out_valid), 32'd0);
        check("load_data", 32'(data), 32'hE1);
        check("load_count", 32'(draw_count), 32'd1);
        seed_load = 1'b0;
        tick();
        check("seed_data", 32'(data), 32'h5A);
        check("seed_small", 32'(small_data), 32'd3);
        check("seed_valid", 32'(out_valid), 32'd1);

        out_ready = 1'b1;
        seed_load = 1'b1;
        seed_in = 8'h00;
        tick();
        check("zload_valid", 32'(out_valid), 32'd0);
        check("zload_count", 32'(draw_count), 32'd2);
        seed_load = 1'b0;
        tick();
`ifdef LFSR_LOCKUP_GUARD_EN
        check("zero_data0", 32'(data), 32'h01);
        check("zero_small0", 32'(small_data), 32'd2);
`else
        check("zero_data0", 32'(data), 32'h00);
        check("zero_small0", 32'(small_data), 32'd1);
`endif
        check("zero_count0", 32'(draw_count), 32'd2);
        tick();
`ifdef LFSR_LOCKUP_GUARD_EN
        check("zero_data1", 32'(data), 32'hB8);
`else
        check("zero_data1", 32'(data), 32'h00);
`endif
        check("zero_small1", 32'(small_data), 32'd1);
        check("zero_count1", 32'(draw_count), 32'd3);

        enable = 1'b0;
        tick();
        check("dis_xfer_valid", 32'(out_valid), 32'd0);
`ifdef LFSR_LOCKUP_GUARD_EN
        check("dis_xfer_data", 32'(data), 32'hB8);
`else
        check("dis_xfer_data", 32'(data), 32'h00);
`endif
        check("dis_xfer_count", 32'(draw_count), 32'd4);
        tick();
        check("dis_idle_valid", 32'(out_valid), 32'd0);
        check("dis_idle_count", 32'(draw_count), 32'd4);
        enable = 1'b1;
        tick();
        check("reen_valid", 32'(out_valid), 32'd1);
`ifdef LFSR_LOCKUP_GUARD_EN
        check("reen_data", 32'(data), 32'h5C);
`else
        check("reen_data", 32'(data), 32'h00);
`endif
        check("reen_small", 32'(small_data), 32'd1);
        check("reen_count", 32'(draw_count), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
